// File: rtl/mem_chk_pkg.sv
// rtl/mem_chk_pkg.sv - shared error indices and read-pipeline entry type for mem_proto_checker
package mem_chk_pkg;

    localparam int ERR_W        = 5;
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_VDROP    = 1;
    localparam int ERR_UNSTABLE = 2;
    localparam int ERR_UNKNOWN  = 3;
    localparam int ERR_DATA     = 4;

    // Entry fields are sized for the widest supported bus; instances zero-extend into them.
    localparam int RD_ADDR_MAX_W = 32;
    localparam int RD_DATA_MAX_W = 64;

    typedef struct packed {
        logic                     vld;
        logic                     written;
        logic [RD_ADDR_MAX_W-1:0] addr;
        logic [RD_DATA_MAX_W-1:0] expected;
    } rd_entry_t;

endpackage

// File: rtl/mem_chk_shadow.sv
// rtl/mem_chk_shadow.sv - shadow copy of memory contents with per-word written flags
module mem_chk_shadow #(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 4,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rwritten_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] written_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            written_q <= '0;
        end else if (we_i) begin
            written_q[waddr_i] <= 1'b1;
        end
    end

    assign rdata_o    = mem_q[raddr_i];
    assign rwritten_o = written_q[raddr_i];

endmodule

// File: rtl/mem_proto_checker.sv
// rtl/mem_proto_checker.sv - passive protocol and data-integrity checker for a valid/ready memory port
module mem_proto_checker
    import mem_chk_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 4,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 16,
    parameter int READ_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  wr_rd_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      w_data_i,
    input  logic [WIDTH-1:0]      rdata_o,
    input  logic                  ready_o,
    input  logic                  clr_i,
    output logic [ERR_W-1:0]      err_o,
    output logic                  err_pulse_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic [CNT_W-1:0]      wr_cnt_o,
    output logic [CNT_W-1:0]      rd_cnt_o,
    output logic [CNT_W-1:0]      chk_cnt_o
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e                state_q, state_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  cap_we_q, cap_we_d;
    logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    logic [WIDTH-1:0]      cap_wdata_q, cap_wdata_d;
    logic [ERR_W-1:0]      err_q, err_set, err_new, proto_err;
    logic                  err_pulse_q;
    logic [ADDR_WIDTH-1:0] first_err_addr_q;
    logic [CNT_W-1:0]      wr_cnt_q, rd_cnt_q, chk_cnt_q;
    rd_entry_t             pipe_q [READ_LAT];
    rd_entry_t             pipe_in, pipe_out;
    logic                  clear, hs, wr_hs, rd_hs, cmp, data_err, unstable;
    logic                  req_unk, rdata_unk;
    logic [WIDTH-1:0]      sh_rdata;
    logic                  sh_written;

    // Transactions coinciding with reset/clear are discarded, like any in-flight state.
    assign clear = rst_i || clr_i;
    assign hs    = valid_i && ready_o && !clear;
    assign wr_hs = hs && wr_rd_en_i;
    assign rd_hs = hs && !wr_rd_en_i;

    mem_chk_shadow #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_shadow (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_i       (wr_hs),
        .waddr_i    (addr_i),
        .wdata_i    (w_data_i),
        .raddr_i    (addr_i),
        .rdata_o    (sh_rdata),
        .rwritten_o (sh_written)
    );

    assign pipe_in  = '{vld: rd_hs, written: sh_written,
                        addr: RD_ADDR_MAX_W'(addr_i), expected: RD_DATA_MAX_W'(sh_rdata)};
    assign pipe_out = pipe_q[READ_LAT-1];
    assign cmp      = pipe_out.vld && pipe_out.written;
    assign data_err = cmp && (pipe_out.expected != RD_DATA_MAX_W'(rdata_o));

`ifdef SYNTHESIS
    assign req_unk   = 1'b0;
    assign rdata_unk = 1'b0;
`else
    assign req_unk   = valid_i && ($isunknown(wr_rd_en_i) || $isunknown(addr_i) ||
                                   (wr_rd_en_i && $isunknown(w_data_i)));
    assign rdata_unk = cmp && $isunknown(rdata_o);
`endif

    assign unstable = (cap_we_q != wr_rd_en_i) || (cap_addr_q != addr_i) ||
                      (cap_we_q && (cap_wdata_q != w_data_i));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        cap_we_d    = cap_we_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        proto_err   = '0;
        case (state_q)
            S_IDLE: begin
                if (valid_i && !ready_o) begin
                    cap_we_d    = wr_rd_en_i;
                    cap_addr_d  = addr_i;
                    cap_wdata_d = w_data_i;
                    if (TIMEOUT_C <= 8'd1) begin
                        proto_err[ERR_TIMEOUT] = 1'b1;
                        wait_cnt_d             = 8'd0;
                    end else begin
                        wait_cnt_d = 8'd1;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                state_d    = S_IDLE;
                wait_cnt_d = 8'd0;
                if (!valid_i) begin
                    proto_err[ERR_VDROP] = 1'b1;
                end else if (unstable) begin
                    proto_err[ERR_UNSTABLE] = 1'b1;
                end else if (!ready_o) begin
                    if (wait_cnt_q + 8'd1 >= TIMEOUT_C) begin
                        proto_err[ERR_TIMEOUT] = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                        state_d    = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        err_set               = proto_err;
        err_set[ERR_UNKNOWN]  = req_unk || rdata_unk;
        err_set[ERR_DATA]     = data_err;
        err_new               = err_set & ~err_q;
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk_i) begin
        if (clear) begin
            state_q          <= S_IDLE;
            wait_cnt_q       <= '0;
            cap_we_q         <= 1'b0;
            cap_addr_q       <= '0;
            cap_wdata_q      <= '0;
            err_q            <= '0;
            err_pulse_q      <= 1'b0;
            first_err_addr_q <= '0;
            wr_cnt_q         <= '0;
            rd_cnt_q         <= '0;
            chk_cnt_q        <= '0;
            for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cap_we_q    <= cap_we_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            err_q       <= err_q | err_set;
            err_pulse_q <= |err_new;
            // Request-side errors report the live address; data errors the address of the read.
            if ((err_q == '0) && (err_set != '0)) begin
                first_err_addr_q <= ((|proto_err) || req_unk) ? addr_i
                                                              : ADDR_WIDTH'(pipe_out.addr);
            end
            wr_cnt_q  <= sat_inc(wr_cnt_q, wr_hs);
            rd_cnt_q  <= sat_inc(rd_cnt_q, rd_hs);
            chk_cnt_q <= sat_inc(chk_cnt_q, cmp);
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign err_o            = err_q;
    assign err_pulse_o      = err_pulse_q;
    assign first_err_addr_o = first_err_addr_q;
    assign wr_cnt_o         = wr_cnt_q;
    assign rd_cnt_o         = rd_cnt_q;
    assign chk_cnt_o        = chk_cnt_q;

endmodule

// File: tb/tb_mem_proto_checker.sv
// tb/tb_mem_proto_checker.sv - self-checking bench for mem_proto_checker (READ_LAT=1 and READ_LAT=3 instances)
module tb_mem_proto_checker;

    localparam int AW = 6;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst, clr, valid, we, ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata1, rdata3;
    logic [4:0]    err1, err3;
    logic          pulse1, pulse3;
    logic [AW-1:0] fea1, fea3;
    logic [15:0]   wr1, rd1, chk1;
    logic [2:0]    wr3, rd3, chk3;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    mem_proto_checker #(.DEPTH(64), .WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(16),
                        .READ_LAT(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_en_i(we), .addr_i(addr),
        .w_data_i(wdata), .rdata_o(rdata1), .ready_o(ready), .clr_i(clr),
        .err_o(err1), .err_pulse_o(pulse1), .first_err_addr_o(fea1),
        .wr_cnt_o(wr1), .rd_cnt_o(rd1), .chk_cnt_o(chk1)
    );

    mem_proto_checker #(.DEPTH(64), .WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(16),
                        .READ_LAT(3), .CNT_W(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .wr_rd_en_i(we), .addr_i(addr),
        .w_data_i(wdata), .rdata_o(rdata3), .ready_o(ready), .clr_i(clr),
        .err_o(err3), .err_pulse_o(pulse3), .first_err_addr_o(fea3),
        .wr_cnt_o(wr3), .rd_cnt_o(rd3), .chk_cnt_o(chk3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        valid = 1'b0; we = 1'b0; addr = '0; wdata = '0; ready = 1'b0;
    endtask

    task automatic do_reset;
        bus_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_clear;
        bus_idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset;
        bus_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if ({err1, pulse1, fea1} !== '0) begin bad++; $display("FAIL reset_err1 got err=%b pulse=%b fea=%0d want 0", err1, pulse1, fea1); end
        total++; if ({wr1, rd1, chk1} !== '0) begin bad++; $display("FAIL reset_cnt1 got wr=%0d rd=%0d chk=%0d want 0", wr1, rd1, chk1); end
        total++; if ({err3, pulse3, fea3, wr3, rd3, chk3} !== '0) begin bad++; $display("FAIL reset_dut3 got err=%b wr=%0d rd=%0d chk=%0d want 0", err3, wr3, rd3, chk3); end
    endtask

    task automatic test_write_read;
        do_reset();
        valid = 1'b1; we = 1'b1; addr = 6'd5; wdata = 4'hA; ready = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        we = 1'b0;
        tick();
        bus_idle(); rdata1 = 4'hA;
        tick();
        total++; if (err1 !== 5'b0) begin bad++; $display("FAIL wr_rd_err got %b want 00000", err1); end
        total++; if ({wr1, rd1, chk1} !== {16'd1, 16'd1, 16'd1}) begin bad++; $display("FAIL wr_rd_cnt got wr=%0d rd=%0d chk=%0d want 1 1 1", wr1, rd1, chk1); end
    endtask

    task automatic test_data_err;
        do_reset();
        valid = 1'b1; we = 1'b1; addr = 6'd3; wdata = 4'h6; ready = 1'b1;
        tick();
        we = 1'b0;
        tick();
        bus_idle(); rdata1 = 4'h9;
        tick();
        total++; if (err1 !== 5'b10000) begin bad++; $display("FAIL data_err got %b want 10000", err1); end
        total++; if (pulse1 !== 1'b1) begin bad++; $display("FAIL data_pulse got %b want 1", pulse1); end
        total++; if (fea1 !== 6'd3) begin bad++; $display("FAIL data_fea got %0d want 3", fea1); end
        tick();
        total++; if ({pulse1, err1} !== {1'b0, 5'b10000}) begin bad++; $display("FAIL data_pulse_once got pulse=%b err=%b want 0 10000", pulse1, err1); end
    endtask

    task automatic test_timeout;
        do_clear();
        valid = 1'b1; we = 1'b0; addr = 6'd9; ready = 1'b0;
        repeat (15) tick();
        total++; if ({err1, pulse1} !== 6'b0) begin bad++; $display("FAIL timeout_early got err=%b pulse=%b want 0", err1, pulse1); end
        tick();
        total++; if ({err1, pulse1, fea1} !== {5'b00001, 1'b1, 6'd9}) begin bad++; $display("FAIL timeout_set got err=%b pulse=%b fea=%0d want 00001 1 9", err1, pulse1, fea1); end
        bus_idle();
        tick();
        total++; if ({err1, pulse1} !== {5'b00001, 1'b0}) begin bad++; $display("FAIL timeout_after got err=%b pulse=%b want 00001 0", err1, pulse1); end
    endtask

    task automatic test_unstable_drop;
        do_clear();
        valid = 1'b1; we = 1'b0; addr = 6'd7; ready = 1'b0;
        tick();
        addr = 6'd8;
        tick();
        total++; if ({err1, pulse1, fea1} !== {5'b00100, 1'b1, 6'd8}) begin bad++; $display("FAIL unstable got err=%b pulse=%b fea=%0d want 00100 1 8", err1, pulse1, fea1); end
        tick();
        total++; if ({err1, pulse1} !== {5'b00100, 1'b0}) begin bad++; $display("FAIL unstable_rewait got err=%b pulse=%b want 00100 0", err1, pulse1); end
        valid = 1'b0;
        tick();
        total++; if ({err1, pulse1, fea1} !== {5'b00110, 1'b1, 6'd8}) begin bad++; $display("FAIL vdrop got err=%b pulse=%b fea=%0d want 00110 1 8", err1, pulse1, fea1); end
        bus_idle();
    endtask

    task automatic test_read_lat3;
        logic [DW-1:0] d [4];
        do_reset();
        for (int k = 0; k < 4; k++) begin
            d[k] = DW'($urandom);
            valid = 1'b1; we = 1'b1; addr = AW'(k); wdata = d[k]; ready = 1'b1;
            tick();
        end
        for (int c = 0; c < 7; c++) begin
            valid = (c < 4); we = 1'b0; addr = AW'(c); ready = 1'b1;
            rdata3 = (c >= 3) ? d[c-3] : DW'($urandom);
            tick();
            total++; if (chk3 !== 3'((c >= 3) ? c - 2 : 0)) begin bad++; $display("FAIL lat3_chk c=%0d got %0d want %0d", c, chk3, (c >= 3) ? c - 2 : 0); end
        end
        total++; if ({err3, wr3, rd3} !== {5'b0, 3'd4, 3'd4}) begin bad++; $display("FAIL lat3_b2b got err=%b wr=%0d rd=%0d want 0 4 4", err3, wr3, rd3); end
        valid = 1'b1; we = 1'b0; addr = 6'd10; ready = 1'b1;
        tick();
        bus_idle();
        repeat (3) begin rdata3 = DW'($urandom); tick(); end
        total++; if ({err3, rd3, chk3} !== {5'b0, 3'd5, 3'd4}) begin bad++; $display("FAIL lat3_unwritten got err=%b rd=%0d chk=%0d want 0 5 4", err3, rd3, chk3); end
    endtask

    task automatic test_saturate;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            valid = 1'b1; we = 1'b1; addr = AW'(k); wdata = DW'(k); ready = 1'b1;
            tick();
        end
        bus_idle();
        total++; if (wr3 !== 3'd7) begin bad++; $display("FAIL sat_wr3 got %0d want 7", wr3); end
        total++; if (wr1 !== 16'd10) begin bad++; $display("FAIL nosat_wr1 got %0d want 10", wr1); end
    endtask

    task automatic test_clear_shadow;
        do_reset();
        valid = 1'b1; we = 1'b1; addr = 6'd2; wdata = 4'h5; ready = 1'b1;
        tick();
        we = 1'b0;
        tick();
        bus_idle(); rdata1 = 4'hC;
        tick();
        total++; if (err1 !== 5'b10000) begin bad++; $display("FAIL clr_pre got %b want 10000", err1); end
        do_clear();
        total++; if ({err1, pulse1, fea1, wr1, rd1, chk1} !== '0) begin bad++; $display("FAIL clr_state got err=%b fea=%0d wr=%0d rd=%0d chk=%0d want 0", err1, fea1, wr1, rd1, chk1); end
        valid = 1'b1; we = 1'b0; addr = 6'd2; ready = 1'b1;
        tick();
        bus_idle(); rdata1 = 4'hC;
        tick();
        total++; if ({err1, chk1, fea1} !== {5'b10000, 16'd1, 6'd2}) begin bad++; $display("FAIL clr_kept got err=%b chk=%0d fea=%0d want 10000 1 2", err1, chk1, fea1); end
        do_reset();
        valid = 1'b1; we = 1'b0; addr = 6'd2; ready = 1'b1;
        tick();
        bus_idle(); rdata1 = 4'hC;
        tick();
        total++; if ({err1, rd1, chk1} !== {5'b0, 16'd1, 16'd0}) begin bad++; $display("FAIL rst_forget got err=%b rd=%0d chk=%0d want 0 1 0", err1, rd1, chk1); end
    endtask

    task automatic test_clr_vs_err;
        do_reset();
        valid = 1'b1; we = 1'b1; addr = 6'd4; wdata = 4'h1; ready = 1'b1;
        tick();
        we = 1'b0;
        tick();
        bus_idle(); rdata1 = 4'h7; clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if ({err1, pulse1, chk1} !== '0) begin bad++; $display("FAIL clr_wins got err=%b pulse=%b chk=%0d want 0", err1, pulse1, chk1); end
    endtask

    task automatic test_random;
        logic [DW-1:0] m_mem [64];
        bit            m_wr  [64];
        int            e_wr, e_rd, e_chk, stall;
        logic [4:0]    e_err;
        logic [AW-1:0] e_fea, pend_a;
        logic [DW-1:0] pend_exp;
        bit            pend_v, pend_w, hold, hs, data_err, e_pulse;
        do_reset();
        for (int i = 0; i < 64; i++) begin m_wr[i] = 1'b0; m_mem[i] = '0; end
        e_wr = 0; e_rd = 0; e_chk = 0; e_err = '0; e_fea = '0;
        pend_v = 1'b0; pend_w = 1'b0; pend_exp = '0; pend_a = '0; hold = 1'b0; stall = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!hold) begin
                valid = ($urandom_range(0, 3) != 0);
                we    = 1'($urandom_range(0, 1));
                addr  = AW'($urandom_range(0, 7));
                wdata = DW'($urandom);
                stall = 0;
            end
            ready = (stall >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (pend_v && pend_w)
                rdata1 = ($urandom_range(0, 24) == 0) ? (pend_exp ^ 4'h5) : pend_exp;
            else
                rdata1 = DW'($urandom);
            // Reference: data returns one cycle after the read; only written words are compared.
            data_err = pend_v && pend_w && (rdata1 != pend_exp);
            if (pend_v && pend_w) e_chk++;
            e_pulse = data_err && !e_err[4];
            if (data_err) begin
                if (e_err == '0) e_fea = pend_a;
                e_err[4] = 1'b1;
            end
            hs       = valid && ready;
            pend_v   = hs && !we;
            pend_exp = m_mem[addr];
            pend_w   = m_wr[addr];
            pend_a   = addr;
            if (hs && we) begin m_mem[addr] = wdata; m_wr[addr] = 1'b1; e_wr++; end
            if (hs && !we) e_rd++;
            hold = valid && !ready;
            if (hold) stall++;
            tick();
            total++; if ({err1, pulse1} !== {e_err, e_pulse}) begin bad++; $display("FAIL rnd_err cyc=%0d got err=%b pulse=%b want %b %b", cyc, err1, pulse1, e_err, e_pulse); end
            total++; if (fea1 !== e_fea) begin bad++; $display("FAIL rnd_fea cyc=%0d got %0d want %0d", cyc, fea1, e_fea); end
            total++; if ({wr1, rd1, chk1} !== {16'(e_wr), 16'(e_rd), 16'(e_chk)}) begin bad++; $display("FAIL rnd_cnt cyc=%0d got wr=%0d rd=%0d chk=%0d want %0d %0d %0d", cyc, wr1, rd1, chk1, e_wr, e_rd, e_chk); end
        end
        bus_idle();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; rdata1 = '0; rdata3 = '0;
        bus_idle();
        test_reset();
        test_write_read();
        test_data_err();
        test_timeout();
        test_unstable_drop();
        test_read_lat3();
        test_saturate();
        test_clear_shadow();
        test_clr_vs_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
